// File: rtl/id_ex_operand_stage_pkg.sv
// id_ex_operand_stage_pkg: ALU opcodes, reset constants and ID/EX register layout
package id_ex_operand_stage_pkg;
  localparam logic [5:0] OP_SLL  = 6'h00;
  localparam logic [5:0] OP_SRL  = 6'h02;
  localparam logic [5:0] OP_SRA  = 6'h03;
  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_ADDU = 6'h21;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_SUBU = 6'h23;
  localparam logic [5:0] OP_OR   = 6'h25;
  localparam logic [5:0] DEF_BUBBLE_OP = OP_ADDU;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm32;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wa;
    logic [5:0]  alu_op;
    logic        b_imm;
    logic        shift_imm;
    logic        shift_var;
    logic        reg_write;
    logic        mem_read;
  } ex_regs_t;
endpackage

// File: rtl/id_ex_operand_stage_fwd_sel.sv
// id_ex_operand_stage_fwd_sel: forwarding mux for one source register; EX/MEM beats MEM/WB, $0 never forwarded
module id_ex_operand_stage_fwd_sel (
  input  logic [4:0]  r,
  input  logic [31:0] reg_val,
  input  logic [4:0]  mem_wa,
  input  logic        mem_we,
  input  logic [31:0] mem_data,
  input  logic [4:0]  wb_wa,
  input  logic        wb_we,
  input  logic [31:0] wb_data,
  output logic [31:0] val
);
  always_comb
    val = (r != 5'd0 && mem_we && mem_wa == r) ? mem_data :
          (r != 5'd0 && wb_we && wb_wa == r)   ? wb_data  : reg_val;
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with forwarded ALU operand selection and load-use detection
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [5:0]  BUBBLE_OP = DEF_BUBBLE_OP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm32,
  input  logic [4:0]  id_shamt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  id_wa,
  input  logic [5:0]  id_alu_op,
  input  logic        id_b_imm,
  input  logic        id_shift_imm,
  input  logic        id_shift_var,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic [4:0]  mem_wa,
  input  logic        mem_we,
  input  logic [31:0] mem_fwd_data,
  input  logic [4:0]  wb_wa,
  input  logic        wb_we,
  input  logic [31:0] wb_data,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [5:0]  alu_op,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_wa,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic [31:0] ex_store_data,
  output logic        load_use_stall
);
  localparam ex_regs_t BUBBLE = '{1'b0, RESET_PC, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                                  BUBBLE_OP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  ex_regs_t q;
  ex_regs_t cap;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;
  always_comb
    cap = id_valid ? '{1'b1, id_pc, id_rs_data, id_rt_data, id_imm32, id_shamt, id_rs, id_rt, id_wa,
                       id_alu_op, id_b_imm, id_shift_imm, id_shift_var, id_reg_write, id_mem_read}
                   : BUBBLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= BUBBLE;
    else if (flush) q <= BUBBLE;
    else if (!stall) q <= cap;
  id_ex_operand_stage_fwd_sel u_fwd_rs (
    .r(q.rs), .reg_val(q.rs_data), .mem_wa(mem_wa), .mem_we(mem_we), .mem_data(mem_fwd_data),
    .wb_wa(wb_wa), .wb_we(wb_we), .wb_data(wb_data), .val(fwd_rs)
  );
  id_ex_operand_stage_fwd_sel u_fwd_rt (
    .r(q.rt), .reg_val(q.rt_data), .mem_wa(mem_wa), .mem_we(mem_we), .mem_data(mem_fwd_data),
    .wb_wa(wb_wa), .wb_we(wb_we), .wb_data(wb_data), .val(fwd_rt)
  );
  // shifts take the shifted value from rt; shift_imm outranks shift_var
  always_comb begin
    alu_x = (q.shift_imm || q.shift_var) ? fwd_rt : fwd_rs;
    alu_y = q.shift_imm ? {27'b0, q.shamt} : q.shift_var ? fwd_rs : q.b_imm ? q.imm32 : fwd_rt;
  end
  assign alu_op         = q.alu_op;
  assign ex_valid       = q.valid;
  assign ex_pc          = q.pc;
  assign ex_wa          = q.wa;
  assign ex_reg_write   = q.reg_write;
  assign ex_mem_read    = q.mem_read;
  assign ex_store_data  = fwd_rt;
  assign load_use_stall = q.valid & q.mem_read & (q.wa != 5'd0) & id_valid &
                          ((id_use_rs & (id_rs == q.wa)) | (id_use_rt & (id_rt == q.wa)));
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed vectors against a behavioural model of the ID/EX operand stage
module tb_id_ex_operand_stage;
  localparam logic [5:0] ADDU = 6'h21, SLL = 6'h00, SRL = 6'h02;
  logic clk = 0, rst_n = 0, stall = 0, flush = 0;
  logic id_valid = 0, id_use_rs = 0, id_use_rt = 0, id_b_imm = 0, id_shift_imm = 0, id_shift_var = 0;
  logic id_reg_write = 0, id_mem_read = 0, mem_we = 0, wb_we = 0;
  logic [31:0] id_pc = 0, id_rs_data = 0, id_rt_data = 0, id_imm32 = 0, mem_fwd_data = 0, wb_data = 0;
  logic [4:0] id_shamt = 0, id_rs = 0, id_rt = 0, id_wa = 0, mem_wa = 0, wb_wa = 0;
  logic [5:0] id_alu_op = 0;
  logic [31:0] alu_x, alu_y, ex_pc, ex_store_data;
  logic [5:0] alu_op;
  logic [4:0] ex_wa;
  logic ex_valid, ex_reg_write, ex_mem_read, load_use_stall;
  int errors = 0, checks = 0;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm32(id_imm32), .id_shamt(id_shamt),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wa(id_wa),
    .id_alu_op(id_alu_op), .id_b_imm(id_b_imm), .id_shift_imm(id_shift_imm), .id_shift_var(id_shift_var),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .mem_wa(mem_wa), .mem_we(mem_we),
    .mem_fwd_data(mem_fwd_data), .wb_wa(wb_wa), .wb_we(wb_we), .wb_data(wb_data),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_wa(ex_wa),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_store_data(ex_store_data),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  // model: the instruction currently sitting in EX
  typedef struct {
    bit v, bimm, si, sv, rw, mr;
    logic [31:0] pc, a, b, imm;
    logic [4:0] sh, rs, rt, wa;
    logic [5:0] op;
  } ins_t;
  ins_t m;

  function automatic ins_t bubble();
    ins_t b;
    b = '{v:0, bimm:0, si:0, sv:0, rw:0, mr:0, pc:32'h3000, a:0, b:0, imm:0, sh:0, rs:0, rt:0, wa:0, op:ADDU};
    return b;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n || flush) m = bubble();
    else if (!stall) m = !id_valid ? bubble() :
      '{v:1, bimm:id_b_imm, si:id_shift_imm, sv:id_shift_var, rw:id_reg_write, mr:id_mem_read,
        pc:id_pc, a:id_rs_data, b:id_rt_data, imm:id_imm32, sh:id_shamt, rs:id_rs, rt:id_rt,
        wa:id_wa, op:id_alu_op};

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
    if (r == 0) return v;
    if (mem_we && mem_wa == r) return mem_fwd_data;
    if (wb_we && wb_wa == r) return wb_data;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] fs, ft, ex, ey;
    logic lu;
    fs = fwd(m.rs, m.a);
    ft = fwd(m.rt, m.b);
    if (m.si) begin ex = ft; ey = {27'b0, m.sh}; end
    else if (m.sv) begin ex = ft; ey = fs; end
    else begin ex = fs; ey = m.bimm ? m.imm : ft; end
    lu = m.v && m.mr && m.wa != 0 && id_valid &&
         ((id_use_rs && id_rs == m.wa) || (id_use_rt && id_rt == m.wa));
    chk("m_alu_x", alu_x, ex);
    chk("m_alu_y", alu_y, ey);
    chk("m_alu_op", {26'b0, alu_op}, {26'b0, m.op});
    chk("m_ex_valid", {31'b0, ex_valid}, {31'b0, m.v});
    chk("m_ex_pc", ex_pc, m.pc);
    chk("m_ex_wa", {27'b0, ex_wa}, {27'b0, m.wa});
    chk("m_ex_reg_write", {31'b0, ex_reg_write}, {31'b0, m.rw});
    chk("m_ex_mem_read", {31'b0, ex_mem_read}, {31'b0, m.mr});
    chk("m_store_data", ex_store_data, ft);
    chk("m_load_use", {31'b0, load_use_stall}, {31'b0, lu});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic nid();
    {id_valid, id_use_rs, id_use_rt, id_b_imm, id_shift_imm, id_shift_var, id_reg_write, id_mem_read} = '0;
    {id_pc, id_rs_data, id_rt_data, id_imm32, id_shamt, id_rs, id_rt, id_wa} = '0;
    id_alu_op = ADDU;
  endtask

  initial begin
    repeat (3) cyc();
    rst_n = 1;
    @(negedge clk); #1;
    chk("rst_valid", {31'b0, ex_valid}, 0);
    chk("rst_pc", ex_pc, 32'h3000);
    chk("rst_op", {26'b0, alu_op}, {26'b0, ADDU});
    chk("rst_x", alu_x, 0);
    chk("rst_y", alu_y, 0);
    // addu $3,$1,$2 with both MEM and WB targeting $1
    cyc(); nid();
    id_valid = 1; id_pc = 32'h3004; id_rs = 1; id_rt = 2; id_wa = 3; id_rs_data = 5; id_rt_data = 7;
    id_use_rs = 1; id_use_rt = 1; id_reg_write = 1;
    cyc(); nid();
    mem_wa = 1; mem_we = 1; mem_fwd_data = 9; wb_wa = 1; wb_we = 1; wb_data = 4;
    @(negedge clk); #1;
    chk("addu_x", alu_x, 9);
    chk("addu_y", alu_y, 7);
    chk("addu_valid", {31'b0, ex_valid}, 1);
    // sll $4,$2,4 with WB forwarding rt
    cyc(); nid();
    id_valid = 1; id_pc = 32'h3008; id_rt = 2; id_rt_data = 1; id_shamt = 4; id_shift_imm = 1;
    id_alu_op = SLL; id_wa = 4; id_reg_write = 1; id_use_rt = 1;
    mem_we = 0; wb_wa = 2; wb_we = 1; wb_data = 8;
    cyc(); nid();
    @(negedge clk); #1;
    chk("sll_x", alu_x, 32'h8);
    chk("sll_y", alu_y, 32'h4);
    chk("sll_op", {26'b0, alu_op}, {26'b0, SLL});
    // shift_imm and shift_var together, then shift_var alone
    cyc(); nid(); wb_we = 0;
    id_valid = 1; id_rs = 1; id_rs_data = 3; id_rt = 2; id_rt_data = 9; id_shamt = 7;
    id_shift_imm = 1; id_shift_var = 1; id_alu_op = SRL;
    cyc(); id_shift_imm = 0;
    @(negedge clk); #1;
    chk("both_y", alu_y, 7);
    cyc(); nid();
    @(negedge clk); #1;
    chk("svar_x", alu_x, 9);
    chk("svar_y", alu_y, 3);
    // lw $5,4($1) in EX; ID reads $5
    cyc(); nid();
    id_valid = 1; id_rs = 1; id_rs_data = 32'h100; id_imm32 = 4; id_b_imm = 1; id_wa = 5;
    id_reg_write = 1; id_mem_read = 1; id_use_rs = 1;
    cyc(); nid();
    id_valid = 1; id_rs = 5; id_rt = 6; id_use_rs = 1; id_use_rt = 1; id_wa = 7; id_reg_write = 1;
    #1 chk("lu_hit", {31'b0, load_use_stall}, 1);
    chk("lw_y", alu_y, 4);
    id_use_rs = 0;
    #1 chk("lu_no_use", {31'b0, load_use_stall}, 0);
    cyc(); nid();
    id_valid = 1; id_rs = 1; id_b_imm = 1; id_wa = 0; id_mem_read = 1; id_use_rs = 1;
    cyc(); nid();
    id_valid = 1; id_rs = 0; id_use_rs = 1;
    #1 chk("lu_wa0", {31'b0, load_use_stall}, 0);
    // stall holds for three cycles while ID keeps changing
    cyc(); nid();
    id_valid = 1; id_pc = 32'h4000; id_wa = 9; id_reg_write = 1;
    cyc(); stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_pc = 32'h5000 + i * 4; id_wa = 5'(10 + i);
      cyc();
      @(negedge clk); #1;
      chk("stall_pc", ex_pc, 32'h4000);
      chk("stall_wa", {27'b0, ex_wa}, 9);
    end
    flush = 1;
    cyc(); flush = 0; stall = 0; nid();
    @(negedge clk); #1;
    chk("flush_valid", {31'b0, ex_valid}, 0);
    chk("flush_rw", {31'b0, ex_reg_write}, 0);
    chk("flush_pc", ex_pc, 32'h3000);
    // $0 is never forwarded
    cyc(); nid();
    id_valid = 1; id_rs = 0; id_rt = 3; id_rt_data = 2; id_use_rs = 1; id_wa = 8;
    cyc(); nid();
    mem_wa = 0; mem_we = 1; mem_fwd_data = 32'hFFFF_FFFF; wb_wa = 0; wb_we = 1; wb_data = 32'h1234;
    #1 chk("zero_x", alu_x, 0);
    // async reset during stall
    cyc(); mem_we = 0; wb_we = 0;
    id_valid = 1; id_pc = 32'h6000; id_reg_write = 1;
    cyc(); stall = 1;
    #2 rst_n = 0;
    #1 chk("areset_valid", {31'b0, ex_valid}, 0);
    chk("areset_pc", ex_pc, 32'h3000);
    cyc(); rst_n = 1; stall = 0; nid();
    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
